dac_7311_tx: RTL
================

// Module: dac_7311_tx
// PURPOSE
//   Dual-channel serial DAC transmitter: outputs sync_n/sclk plus one data line per channel to two DAC7311-style 16-bit-frame DACs.
//   Frames are shifted MSB-first and the DAC samples on sclk falling edges.
//   Sits on the output side of the control loop, mirroring the ADC serial front end on the input side.
//   Accepts one word per channel per frame through a valid/ready handshake.
// PARAMETERS
//   DAC_LENGTH  12  DAC code width per channel; must satisfy DAC_LENGTH <= FRAME_BITS-2
//   FRAME_BITS  16  bits per serial frame
//   HALF_DIV     5  CLK100MHz cycles per sclk half-period (>=1); sclk = 100MHz/(2*HALF_DIV)
//   GAP_CYCLES   4  cycles sync_n is held high after a frame before in_ready returns (>=1)
// PORTS
//   CLK100MHz  in   1           system clock, all logic on rising edge
//   ARESETN    in   1           asynchronous active-low reset
//   in_valid   in   1           new word pair available
//   in_ready   out  1           block can accept a word pair this cycle
//   dac0       in   DAC_LENGTH  channel 0 code
//   dac1       in   DAC_LENGTH  channel 1 code
//   pd_mode    in   2           power-down bits, common to both channels
//   sync_n     out  1           frame select to both DACs, active low
//   sclk       out  1           serial clock, idle high
//   sdo0       out  1           channel 0 serial data
//   sdo1       out  1           channel 1 serial data
//   done       out  1           one-cycle pulse when a frame completes
// BEHAVIOUR
//   Reset values (async): sync_n=1, sclk=1, sdo0=sdo1=0, done=0, in_ready=0, state=IDLE, counters=0.
//   Reset can assert at any time. Outputs go idle immediately, no done is produced, and the aborted frame is discarded.
//   in_ready is registered. It is 1 only in IDLE and first rises on the first clock after ARESETN releases.
//   Handshake: a transfer happens on a rising edge where in_valid && in_ready.
//     The frame register latches {pd_mode, dacN, (FRAME_BITS-2-DAC_LENGTH) zeros}, MSB first.
//     in_ready drops on the next cycle.
//   The latched frame is immutable. Changes on dac0/dac1/pd_mode/in_valid after acceptance have no effect on the frame.
//   States:
//     IDLE -> SETUP on accept.
//     SETUP: sync_n=0, sclk=1, sdoN=frame bit MSB. Lasts HALF_DIV cycles, then SHIFT.
//     SHIFT: per bit, sclk=0 for HALF_DIV cycles, then sclk=1 for HALF_DIV cycles.
//       On each 0->1 sclk transition, sdoN advances to the next bit, except after the last bit.
//       FRAME_BITS falling edges per frame. The bit counter counts 0..FRAME_BITS-1; the divider counts 0..HALF_DIV-1.
//       Both counters must wrap to 0 exactly and must never overrun.
//     SHIFT -> GAP after the last high half-period.
//       First GAP cycle: sync_n=1, sclk=1, sdoN=0, done=1 for exactly this cycle.
//     GAP lasts GAP_CYCLES cycles, including the done cycle, then IDLE with in_ready=1.
//   Timing: accept on cycle 0. sync_n is low on cycles 1..(1+2*FRAME_BITS)*HALF_DIV.
//     With defaults: sync_n low for 165 cycles, done on cycle 166, in_ready high on cycle 170.
//   Back-to-back: with in_valid held high, the next accept occurs on the first IDLE cycle.
//     sync_n is high for GAP_CYCLES+1 cycles between frames.
//   Both channels share the counters and are bit-aligned on every cycle.
//   All outputs are driven directly from flops, with no glitches.
// CONFIGURATION
//   DAC_FRAME_CNT_EN defined:
//     Adds output port frame_cnt [31:0], reset 0.
//     Increments by 1 in the cycle after each done pulse and wraps 0xFFFFFFFF -> 0.
//     Aborted frames are not counted.
//   DAC_FRAME_CNT_EN undefined: frame_cnt port and counter logic are absent. All other behaviour is identical.
// TESTING
//   T1 reset:
//     Hold ARESETN=0 -> sync_n=1, sclk=1, sdo0=sdo1=0, done=0, in_ready=0.
//     in_ready=1 on the first cycle after release.
//   T2 basic frame (defaults):
//     dac0=12'hA5C, dac1=12'h3F0, pd_mode=0 -> words sampled on sclk falling edges are 16'h2970 / 16'h0FC0.
//     16 falling edges; sync_n low 165 cycles; done on cycle 166.
//   T3 power-down bits: dac0=12'hFFF, pd_mode=2'b11 -> channel 0 word 16'hFFFC.
//   T4 back-to-back: in_valid held high for 3 frames -> sync_n high exactly 5 cycles between frames, 3 done pulses.
//   T5 stability: toggle dac0/dac1/in_valid every cycle mid-frame -> shifted words equal the values latched at accept.
//   T6 abort:
//     Pulse ARESETN low during the 7th bit -> outputs idle immediately, no done.
//     Next frame 12'h001 shifts 16'h0004 cleanly.
//     With DAC_FRAME_CNT_EN: frame_cnt=1, not 2.

Source files
------------

// File: rtl/dac_7311_tx.sv
// rtl/dac_7311_tx.sv - dual-channel DAC7311-style serial transmitter
// Optional frame counter output enabled by defining DAC_FRAME_CNT_EN.
module dac_7311_tx #(
    parameter int DAC_LENGTH = 12,
    parameter int FRAME_BITS = 16,
    parameter int HALF_DIV   = 5,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  CLK100MHz,
    input  logic                  ARESETN,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DAC_LENGTH-1:0] dac0,
    input  logic [DAC_LENGTH-1:0] dac1,
    input  logic [1:0]            pd_mode,
    output logic                  sync_n,
    output logic                  sclk,
    output logic                  sdo0,
    output logic                  sdo1,
    output logic                  done
`ifdef DAC_FRAME_CNT_EN
    ,
    output logic [31:0]           frame_cnt
`endif
);

    localparam int PAD   = FRAME_BITS - 2 - DAC_LENGTH;
    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t                state_q;
    logic [DIV_W-1:0]      div_q;
    logic [BIT_W-1:0]      bit_q;
    logic [GAP_W-1:0]      gap_q;
    logic [FRAME_BITS-1:0] frame0_q, frame1_q;
    logic [FRAME_BITS-1:0] frame0_d, frame1_d;
    logic                  in_ready_q, sync_n_q, sclk_q, sdo0_q, sdo1_q, done_q;
    logic                  div_last, bit_last, gap_last;
    logic [BIT_W-1:0]      nxt_idx;

    // {pd_mode, code, zero padding}, MSB shifted first
    assign frame0_d = FRAME_BITS'({pd_mode, dac0}) << PAD;
    assign frame1_d = FRAME_BITS'({pd_mode, dac1}) << PAD;

    assign div_last = (div_q == DIV_W'(HALF_DIV - 1));
    assign bit_last = (bit_q == BIT_W'(FRAME_BITS - 1));
    assign gap_last = (gap_q == GAP_W'(GAP_CYCLES - 1));
    assign nxt_idx  = BIT_W'(FRAME_BITS - 2) - bit_q;

    always_ff @(posedge CLK100MHz or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            frame0_q   <= '0;
            frame1_q   <= '0;
            in_ready_q <= 1'b0;
            sync_n_q   <= 1'b1;
            sclk_q     <= 1'b1;
            sdo0_q     <= 1'b0;
            sdo1_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        frame0_q   <= frame0_d;
                        frame1_q   <= frame1_d;
                        sdo0_q     <= frame0_d[FRAME_BITS-1];
                        sdo1_q     <= frame1_d[FRAME_BITS-1];
                        sync_n_q   <= 1'b0;
                        sclk_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        div_q      <= '0;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_last) begin
                        div_q   <= '0;
                        bit_q   <= '0;
                        sclk_q  <= 1'b0;
                        state_q <= SHIFT;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (!div_last) begin
                        div_q <= div_q + DIV_W'(1);
                    end else begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            // rising sclk: present the next bit for the following falling edge
                            sclk_q <= 1'b1;
                            if (!bit_last) begin
                                sdo0_q <= frame0_q[nxt_idx];
                                sdo1_q <= frame1_q[nxt_idx];
                            end
                        end else if (bit_last) begin
                            sync_n_q <= 1'b1;
                            sdo0_q   <= 1'b0;
                            sdo1_q   <= 1'b0;
                            done_q   <= 1'b1;
                            gap_q    <= '0;
                            bit_q    <= '0;
                            state_q  <= GAP;
                        end else begin
                            sclk_q <= 1'b0;
                            bit_q  <= bit_q + BIT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        gap_q      <= '0;
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DAC_FRAME_CNT_EN
    logic [31:0] frame_cnt_q;

    always_ff @(posedge CLK100MHz or negedge ARESETN) begin
        if (!ARESETN) begin
            frame_cnt_q <= '0;
        end else if (done_q) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign in_ready = in_ready_q;
    assign sync_n   = sync_n_q;
    assign sclk     = sclk_q;
    assign sdo0     = sdo0_q;
    assign sdo1     = sdo1_q;
    assign done     = done_q;

endmodule
